// File: rtl/cond_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_unit_if
// Purpose  : Request/response handshake bundle between a branch requester
//            (master) and the conditional-branch unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface cond_branch_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_cond;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_taken;
    logic [3:0] rsp_flags;

    // Requester side: issues conditions, consumes decisions
    modport master (
        output req_valid, req_cond, rsp_ready,
        input  req_ready, rsp_valid, rsp_taken, rsp_flags
    );

    // Branch unit side
    modport slave (
        input  req_valid, req_cond, rsp_ready,
        output req_ready, rsp_valid, rsp_taken, rsp_flags
    );
endinterface
`default_nettype wire

// File: rtl/cond_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_unit
// Purpose  : Latches the adder status word (V,N,Z,C) into a flag register and
//            resolves conditional-branch requests against it through a
//            one-entry valid/ready response register. Keeps saturating
//            evaluation / taken statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module cond_branch_unit #(
    parameter int FORWARD = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        status_in,
    input  logic              set_flags,
    output logic [3:0]        flags_q,
    cond_branch_unit_if.slave bus,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  eval_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam bit               c_fwd     = (FORWARD != 0);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    localparam logic [3:0] c_cc_eq = 4'h0;
    localparam logic [3:0] c_cc_ne = 4'h1;
    localparam logic [3:0] c_cc_hs = 4'h2;
    localparam logic [3:0] c_cc_lo = 4'h3;
    localparam logic [3:0] c_cc_mi = 4'h4;
    localparam logic [3:0] c_cc_pl = 4'h5;
    localparam logic [3:0] c_cc_vs = 4'h6;
    localparam logic [3:0] c_cc_vc = 4'h7;
    localparam logic [3:0] c_cc_hi = 4'h8;
    localparam logic [3:0] c_cc_ls = 4'h9;
    localparam logic [3:0] c_cc_ge = 4'hA;
    localparam logic [3:0] c_cc_lt = 4'hB;
    localparam logic [3:0] c_cc_gt = 4'hC;
    localparam logic [3:0] c_cc_le = 4'hD;
    localparam logic [3:0] c_cc_al = 4'hE;

    logic [3:0]       r_flags;
    logic             r_rsp_valid;
    logic             r_rsp_taken;
    logic [3:0]       r_rsp_flags;
    logic [CNT_W-1:0] r_eval_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [3:0] w_ef;
    logic       w_v, w_n, w_z, w_c;
    logic       w_cond_true;
    logic       w_accept;
    logic       w_pop;

    // Forwarding lets a request see the status word being written this cycle
    assign w_ef = (c_fwd && set_flags) ? status_in : r_flags;
    assign w_v  = w_ef[0];
    assign w_n  = w_ef[1];
    assign w_z  = w_ef[2];
    assign w_c  = w_ef[3];

    // The slot frees up when empty or when its content leaves this cycle
    assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_pop         = r_rsp_valid && bus.rsp_ready;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_taken = r_rsp_taken;
    assign bus.rsp_flags = r_rsp_flags;
    assign flags_q       = r_flags;
    assign eval_cnt      = r_eval_cnt;
    assign taken_cnt     = r_taken_cnt;

    // Condition decode against the evaluation flags; code F (never) falls to default
    always_comb begin
        w_cond_true = 1'b0;
        case (bus.req_cond)
            c_cc_eq: w_cond_true = w_z;
            c_cc_ne: w_cond_true = !w_z;
            c_cc_hs: w_cond_true = w_c;
            c_cc_lo: w_cond_true = !w_c;
            c_cc_mi: w_cond_true = w_n;
            c_cc_pl: w_cond_true = !w_n;
            c_cc_vs: w_cond_true = w_v;
            c_cc_vc: w_cond_true = !w_v;
            c_cc_hi: w_cond_true = w_c && !w_z;
            c_cc_ls: w_cond_true = !w_c || w_z;
            c_cc_ge: w_cond_true = (w_n == w_v);
            c_cc_lt: w_cond_true = (w_n != w_v);
            c_cc_gt: w_cond_true = !w_z && (w_n == w_v);
            c_cc_le: w_cond_true = w_z || (w_n != w_v);
            c_cc_al: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Architectural flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (set_flags) begin
            r_flags <= status_in;
        end
    end

    // One-entry response register; payload only moves on accept so it holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_taken <= 1'b0;
            r_rsp_flags <= 4'b0000;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_taken <= w_cond_true;
            r_rsp_flags <= w_ef;
        end else if (w_pop) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eval_cnt  <= '0;
            r_taken_cnt <= '0;
        end else if (clr_cnt) begin
            r_eval_cnt  <= '0;
            r_taken_cnt <= '0;
        end else if (w_accept) begin
            if (r_eval_cnt != c_cnt_max) begin
                r_eval_cnt <= r_eval_cnt + 1'b1;
            end
            if (w_cond_true && (r_taken_cnt != c_cnt_max)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cond_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_branch_unit
// Purpose  : Directed bench for cond_branch_unit. Two instances (FORWARD=1 and
//            FORWARD=0, both CNT_W=4) share stimulus; a behavioural model is
//            compared against both on every falling edge, and literal
//            expectations pin the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_branch_unit;

    localparam int c_cnt_max = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] status_in;
    logic       set_flags;
    logic       clr_cnt;
    logic       req_valid;
    logic [3:0] req_cond;
    logic       rsp_ready;

    logic [3:0] flags_q0, flags_q1;
    logic [3:0] ev0, ev1, tk0, tk1;

    int n_checks = 0;
    int n_errors = 0;

    cond_branch_unit_if if0 ();
    cond_branch_unit_if if1 ();

    assign if0.req_valid = req_valid;
    assign if0.req_cond  = req_cond;
    assign if0.rsp_ready = rsp_ready;
    assign if1.req_valid = req_valid;
    assign if1.req_cond  = req_cond;
    assign if1.rsp_ready = rsp_ready;

    cond_branch_unit #(.FORWARD(0), .CNT_W(4)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .status_in (status_in),
        .set_flags (set_flags),
        .flags_q   (flags_q0),
        .bus       (if0),
        .clr_cnt   (clr_cnt),
        .eval_cnt  (ev0),
        .taken_cnt (tk0)
    );

    cond_branch_unit #(.FORWARD(1), .CNT_W(4)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .status_in (status_in),
        .set_flags (set_flags),
        .flags_q   (flags_q1),
        .bus       (if1),
        .clr_cnt   (clr_cnt),
        .eval_cnt  (ev1),
        .taken_cnt (tk1)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model (index 0: FORWARD=0, index 1: FORWARD=1)
    // ------------------------------------------------------------------
    logic [3:0] m_flags [2];
    logic       m_v     [2];
    logic       m_t     [2];
    logic [3:0] m_f     [2];
    int         m_ev    [2];
    int         m_tk    [2];

    // Branch condition straight from the N/Z/C/V rules
    function automatic logic cond_model(input logic [3:0] code, input logic [3:0] f);
        logic v, n, z, c, r;
        v = f[0]; n = f[1]; z = f[2]; c = f[3];
        r = 1'b0;
        case (code)
            4'h0: r = z;
            4'h1: r = !z;
            4'h2: r = c;
            4'h3: r = !c;
            4'h4: r = n;
            4'h5: r = !n;
            4'h6: r = v;
            4'h7: r = !v;
            4'h8: r = c && !z;
            4'h9: r = !c || z;
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = !z && (n == v);
            4'hD: r = z || (n != v);
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ef_of(input int i);
        return (i == 1 && set_flags) ? status_in : m_flags[i];
    endfunction

    function automatic logic acc_of(input int i);
        return req_valid && (!m_v[i] || rsp_ready);
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= c_cnt_max) ? c_cnt_max : x + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_flags[i] <= 4'b0;
                m_v[i]     <= 1'b0;
                m_t[i]     <= 1'b0;
                m_f[i]     <= 4'b0;
                m_ev[i]    <= 0;
                m_tk[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (set_flags) m_flags[i] <= status_in;
                if (acc_of(i)) begin
                    m_v[i] <= 1'b1;
                    m_t[i] <= cond_model(req_cond, ef_of(i));
                    m_f[i] <= ef_of(i);
                end else if (m_v[i] && rsp_ready) begin
                    m_v[i] <= 1'b0;
                end
                if (clr_cnt) begin
                    m_ev[i] <= 0;
                    m_tk[i] <= 0;
                end else if (acc_of(i)) begin
                    m_ev[i] <= sat_inc(m_ev[i]);
                    if (cond_model(req_cond, ef_of(i))) m_tk[i] <= sat_inc(m_tk[i]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input logic [3:0] fq, input logic v, input logic rdy,
                       input logic t, input logic [3:0] rf, input logic [3:0] ev,
                       input logic [3:0] tk);
        chk($sformatf("u%0d flags_q", i), {28'b0, fq}, {28'b0, m_flags[i]});
        chk($sformatf("u%0d rsp_valid", i), {31'b0, v}, {31'b0, m_v[i]});
        chk($sformatf("u%0d req_ready", i), {31'b0, rdy}, {31'b0, (!m_v[i] || rsp_ready)});
        chk($sformatf("u%0d eval_cnt", i), {28'b0, ev}, m_ev[i]);
        chk($sformatf("u%0d taken_cnt", i), {28'b0, tk}, m_tk[i]);
        if (m_v[i]) begin
            chk($sformatf("u%0d rsp_taken", i), {31'b0, t}, {31'b0, m_t[i]});
            chk($sformatf("u%0d rsp_flags", i), {28'b0, rf}, {28'b0, m_f[i]});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp(0, flags_q0, if0.rsp_valid, if0.req_ready, if0.rsp_taken, if0.rsp_flags, ev0, tk0);
            cmp(1, flags_q1, if1.rsp_valid, if1.req_ready, if1.rsp_taken, if1.rsp_flags, ev1, tk1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {status[3:0], cond[3:0], expected taken}
    logic [8:0] t4 [10] = '{
        {4'b0010, 4'hA, 1'b0}, {4'b0010, 4'hB, 1'b1}, {4'b0010, 4'hD, 1'b1},
        {4'b0011, 4'hC, 1'b1}, {4'b1000, 4'h8, 1'b1}, {4'b1100, 4'h9, 1'b1},
        {4'b1111, 4'hF, 1'b0}, {4'b0000, 4'hE, 1'b1}, {4'b0001, 4'h6, 1'b1},
        {4'b1000, 4'h3, 1'b0}
    };
    logic [3:0] t5_cond [4] = '{4'h0, 4'h5, 4'hE, 4'hB};
    logic [3:0] t5_stat [3] = '{4'b1010, 4'b0110, 4'b1101};

    logic       cap_t;
    logic [3:0] cap_f;

    initial begin
        rst_n = 1'b0; status_in = 4'b0; set_flags = 1'b0; clr_cnt = 1'b0;
        req_valid = 1'b0; req_cond = 4'h0; rsp_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;

        // 1: async reset while a response is pending
        rsp_ready = 1'b0; req_valid = 1'b1; req_cond = 4'hE;
        status_in = 4'b1111; set_flags = 1'b1;
        tick();
        req_valid = 1'b0; set_flags = 1'b0;
        chk("rst pre rsp_valid", {31'b0, if1.rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst rsp_valid", {31'b0, if1.rsp_valid}, 32'd0);
        chk("rst rsp_taken", {31'b0, if1.rsp_taken}, 32'd0);
        chk("rst rsp_flags", {28'b0, if1.rsp_flags}, 32'd0);
        chk("rst flags_q", {28'b0, flags_q1}, 32'd0);
        chk("rst eval_cnt", {28'b0, ev1}, 32'd0);
        chk("rst taken_cnt", {28'b0, tk1}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst req_ready", {31'b0, if1.req_ready}, 32'd1);
        rsp_ready = 1'b1;
        tick();

        // 2: flags then EQ / NE
        status_in = 4'b0100; set_flags = 1'b1;
        tick();
        set_flags = 1'b0; req_valid = 1'b1; req_cond = 4'h0;
        tick();
        chk("eq taken", {31'b0, if1.rsp_taken}, 32'd1);
        chk("eq flags", {28'b0, if1.rsp_flags}, 32'h4);
        req_cond = 4'h1;
        tick();
        chk("ne taken", {31'b0, if1.rsp_taken}, 32'd0);
        req_valid = 1'b0;

        // 3: forwarding vs registered flags
        status_in = 4'b0000; set_flags = 1'b1;
        tick();
        status_in = 4'b0010; req_valid = 1'b1; req_cond = 4'h4;
        tick();
        chk("fwd1 mi taken", {31'b0, if1.rsp_taken}, 32'd1);
        chk("fwd0 mi taken", {31'b0, if0.rsp_taken}, 32'd0);
        req_valid = 1'b0; set_flags = 1'b0;
        tick();

        // 4: condition table from registered flags
        for (int k = 0; k < 10; k++) begin
            status_in = t4[k][8:5]; set_flags = 1'b1; req_valid = 1'b0;
            tick();
            set_flags = 1'b0; req_valid = 1'b1; req_cond = t4[k][4:1];
            tick();
            chk($sformatf("cond%0h u1", t4[k][4:1]), {31'b0, if1.rsp_taken}, {31'b0, t4[k][0]});
            chk($sformatf("cond%0h u0", t4[k][4:1]), {31'b0, if0.rsp_taken}, {31'b0, t4[k][0]});
            req_valid = 1'b0;
        end
        tick();

        // 5: backpressure, flags changing underneath, then full-rate drain
        rsp_ready = 1'b0; req_valid = 1'b1; req_cond = 4'hE;
        status_in = 4'b0001; set_flags = 1'b1;
        tick();
        cap_t = if1.rsp_taken; cap_f = if1.rsp_flags;
        chk("bp first flags", {28'b0, cap_f}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            status_in = t5_stat[k]; req_cond = 4'hF;
            tick();
            chk("bp req_ready", {31'b0, if1.req_ready}, 32'd0);
            chk("bp hold taken", {31'b0, if1.rsp_taken}, {31'b0, cap_t});
            chk("bp hold flags", {28'b0, if1.rsp_flags}, {28'b0, cap_f});
        end
        set_flags = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_cond = t5_cond[k];
            tick();
            chk("drain rsp_valid", {31'b0, if1.rsp_valid}, 32'd1);
        end
        req_valid = 1'b0;
        tick();
        chk("drain empty", {31'b0, if1.rsp_valid}, 32'd0);

        // 6: saturation at CNT_W=4, then clear beats a same-cycle accept
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0; req_valid = 1'b1; req_cond = 4'hE;
        for (int k = 0; k < 20; k++) tick();
        chk("sat eval_cnt", {28'b0, ev1}, 32'hF);
        chk("sat taken_cnt", {28'b0, tk1}, 32'hF);
        chk("model sat eval", m_ev[1], 32'd15);
        clr_cnt = 1'b1;
        tick();
        chk("clr eval_cnt", {28'b0, ev1}, 32'd0);
        chk("clr taken_cnt", {28'b0, tk1}, 32'd0);
        chk("model clr eval", m_ev[1], 32'd0);
        clr_cnt = 1'b0; req_valid = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
